// File: rtl/issue_queue_nxm.sv
// Out-of-order issue queue: DISP-wide all-or-nothing dispatch into SIZE slots,
// tag wakeup, oldest-index select of up to ISSUE ready uops, branch kill/clear.
module issue_queue_nxm #(
    parameter int WIDTH_UOP = 7,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_REG = 7,
    parameter int SIZE      = 16,
    parameter int DISP      = 4,
    parameter int ISSUE     = 2,
    parameter int WAKE      = 4,
    localparam int W_INST   = WIDTH_UOP + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG,
    localparam int CNT_W    = $clog2(SIZE+1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [DISP-1:0]           i_disp_valid,
    input  logic [DISP*W_INST-1:0]    i_disp_inst,
    input  logic [DISP-1:0]           i_disp_p1,
    input  logic [DISP-1:0]           i_disp_p2,
    output logic                      o_disp_ready,
    input  logic [WAKE-1:0]           i_wake_valid,
    input  logic [WAKE*WIDTH_REG-1:0] i_wake_addr,
    input  logic                      i_br_valid,
    input  logic                      i_br_kill,
    input  logic [WIDTH_BRM-1:0]      i_br_mask,
    output logic [ISSUE-1:0]          o_iss_valid,
    output logic [ISSUE*W_INST-1:0]   o_iss_inst,
    output logic [CNT_W-1:0]          o_count
);

    localparam int BRM_LO = 3*WIDTH_REG + WIDTH_TAG;

    logic [SIZE-1:0]         val, p1, p2;
    logic [W_INST-1:0]       pay [SIZE];

    logic [SIZE-1:0]         val_n, p1_n, p2_n;
    logic [W_INST-1:0]       pay_n [SIZE];
    logic [ISSUE-1:0]        iss_valid_n;
    logic [ISSUE*W_INST-1:0] iss_inst_n;
    logic [CNT_W-1:0]        count_n;
    logic [W_INST-1:0]       br_clr;
    logic                    kill;

    function automatic logic woken(input logic [WIDTH_REG-1:0]      addr,
                                   input logic [WAKE-1:0]           wv,
                                   input logic [WAKE*WIDTH_REG-1:0] wa);
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < WAKE; w++)
            if (wv[w] && wa[w*WIDTH_REG +: WIDTH_REG] == addr)
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic brm_hit(input logic [W_INST-1:0] p, input logic [WIDTH_BRM-1:0] m);
        return |(p[BRM_LO +: WIDTH_BRM] & m);
    endfunction

    assign o_disp_ready = i_en && ((SIZE - int'(o_count)) >= DISP);
    assign kill         = i_br_valid & i_br_kill;
    assign br_clr       = (i_br_valid && !i_br_kill) ? (W_INST'(i_br_mask) << BRM_LO) : '0;

    always_comb begin : comb_next
        int unsigned       scnt;
        int unsigned       fcnt;
        int unsigned       lcnt;
        logic [W_INST-1:0] lane;
        val_n       = val;
        p1_n        = p1;
        p2_n        = p2;
        iss_valid_n = '0;
        iss_inst_n  = o_iss_inst;
        count_n     = '0;
        scnt        = 0;
        fcnt        = 0;
        lcnt        = 0;
        lane        = '0;

        for (int unsigned i = 0; i < SIZE; i++) begin
            pay_n[i] = pay[i] & ~br_clr;
            if (kill && brm_hit(pay[i], i_br_mask))
                val_n[i] = 1'b0;
            p1_n[i] = p1[i] | woken(pay[i][WIDTH_REG-1:0], i_wake_valid, i_wake_addr);
            p2_n[i] = p2[i] | woken(pay[i][2*WIDTH_REG-1:WIDTH_REG], i_wake_valid, i_wake_addr);
        end

        // Select sees kill-filtered val but pre-wakeup readiness, so kill wins
        // and a woken entry waits one cycle.
        if (i_en) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (val_n[i] && p1[i] && p2[i]) begin
                    for (int unsigned k = 0; k < ISSUE; k++) begin
                        if (k == scnt) begin
                            iss_valid_n[k]                 = 1'b1;
                            iss_inst_n[k*W_INST +: W_INST] = pay_n[i];
                        end
                    end
                    if (scnt < ISSUE)
                        val_n[i] = 1'b0;
                    scnt++;
                end
            end
        end

        // n-th surviving lane goes to the n-th slot that was free at cycle start.
        if (o_disp_ready) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (!val[i]) begin
                    lcnt = 0;
                    for (int unsigned j = 0; j < DISP; j++) begin
                        lane = i_disp_inst[j*W_INST +: W_INST];
                        if (i_disp_valid[j] && !(kill && brm_hit(lane, i_br_mask))) begin
                            if (lcnt == fcnt) begin
                                val_n[i] = 1'b1;
                                pay_n[i] = lane & ~br_clr;
                                p1_n[i]  = i_disp_p1[j] | woken(lane[WIDTH_REG-1:0], i_wake_valid, i_wake_addr);
                                p2_n[i]  = i_disp_p2[j] | woken(lane[2*WIDTH_REG-1:WIDTH_REG], i_wake_valid, i_wake_addr);
                            end
                            lcnt++;
                        end
                    end
                    fcnt++;
                end
            end
        end

        for (int unsigned i = 0; i < SIZE; i++)
            count_n = count_n + CNT_W'(val_n[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val         <= '0;
            p1          <= '0;
            p2          <= '0;
            o_iss_valid <= '0;
            o_iss_inst  <= '0;
            o_count     <= '0;
        end else begin
            val         <= val_n;
            p1          <= p1_n;
            p2          <= p2_n;
            o_iss_valid <= iss_valid_n;
            o_iss_inst  <= iss_inst_n;
            o_count     <= count_n;
        end
        for (int unsigned i = 0; i < SIZE; i++)
            pay[i] <= pay_n[i];
    end

endmodule
